servo_ramp_ctrl: RTL and testbench

Rate-limited, two-requester duty controller for the servo PWM driver. It arbitrates position commands from two sources, for example the keypad path and the auto-sweep path. It clamps each accepted target to the legal servo range. It then slews the 13-bit duty word toward the target by a bounded step once per PWM frame, so the output stage never sees a mid-frame change or an abrupt jump. It runs on the same divided clock as the PWM counter and drives its `data` input directly.

---
 rtl/servo_ctrl_pkg.sv | 19 +
 rtl/servo_frame_timer.sv | 28 ++
 rtl/servo_ramp_ctrl.sv | 107 ++++++++++
 tb/tb_servo_ramp_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/servo_ctrl_pkg.sv
// servo_ctrl_pkg: shared widths, defaults, FSM states and clamp helper for the servo ramp controller
package servo_ctrl_pkg;

    localparam int DUTY_W       = 13;
    localparam int DEF_DUTY_MIN = 50;
    localparam int DEF_DUTY_MAX = 250;
    localparam int DEF_DUTY_INIT = 150;

    typedef enum logic [1:0] {IDLE, RAMP, HOLD, DONE} state_t;

    function automatic logic [DUTY_W-1:0] clamp(
        input logic [DUTY_W-1:0] v,
        input logic [DUTY_W-1:0] lo,
        input logic [DUTY_W-1:0] hi
    );
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// servo_frame_timer: PWM-aligned frame counter with end-of-frame strobe and registered frame-start flag
module servo_frame_timer #(
    parameter int PERIOD = 2000
) (
    input  logic gen_clk,
    input  logic i_rst_n,
    output logic o_boundary,
    output logic o_frame_start
);

    localparam int FC_W = $clog2(PERIOD + 2);

    logic [FC_W-1:0] fc;

    assign o_boundary = fc == FC_W'(PERIOD);

    // count 0..PERIOD; frame_start is registered so it is high exactly while fc == 0
    always_ff @(posedge gen_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fc            <= '0;
            o_frame_start <= 1'b1;
        end else begin
            fc            <= o_boundary ? '0 : fc + 1'b1;
            o_frame_start <= o_boundary;
        end
    end

endmodule

// File: rtl/servo_ramp_ctrl.sv
// servo_ramp_ctrl: two-requester round-robin duty controller that slews the PWM duty once per frame
module servo_ramp_ctrl
    import servo_ctrl_pkg::*;
#(
    parameter int PERIOD      = 2000,
    parameter int DUTY_MIN    = DEF_DUTY_MIN,
    parameter int DUTY_MAX    = DEF_DUTY_MAX,
    parameter int DUTY_INIT   = DEF_DUTY_INIT,
    parameter int STEP        = 5,
    parameter int HOLD_FRAMES = 10
) (
    input  logic              gen_clk,
    input  logic              i_rst_n,
    input  logic              i_req0_valid,
    input  logic [DUTY_W-1:0] i_req0_target,
    output logic              o_req0_ready,
    input  logic              i_req1_valid,
    input  logic [DUTY_W-1:0] i_req1_target,
    output logic              o_req1_ready,
    output logic [DUTY_W-1:0] o_duty,
    output logic              o_frame_start,
    output logic              o_busy,
    output logic              o_done
);

    localparam int HC_W = $clog2(HOLD_FRAMES + 1) + 1;
    localparam logic [DUTY_W-1:0] D_MIN  = DUTY_W'(DUTY_MIN);
    localparam logic [DUTY_W-1:0] D_MAX  = DUTY_W'(DUTY_MAX);
    localparam logic [DUTY_W-1:0] D_INIT = DUTY_W'(DUTY_INIT);
    localparam logic [DUTY_W-1:0] D_STEP = DUTY_W'(STEP);
    localparam logic [HC_W-1:0]   HOLD_N = HC_W'(HOLD_FRAMES);

    state_t            state, state_n;
    logic [DUTY_W-1:0] tgt, tgt_n, duty_n, sel_tgt, diff, step, ramp_d;
    logic [HC_W-1:0]   hold_cnt, hold_n;
    logic              last, last_n, boundary, idle, gnt0, gnt1, up;

    servo_frame_timer #(.PERIOD(PERIOD)) u_timer (
        .gen_clk       (gen_clk),
        .i_rst_n       (i_rst_n),
        .o_boundary    (boundary),
        .o_frame_start (o_frame_start)
    );

    // round-robin: a lone requester wins, a tie goes to the one not served last
    assign idle         = state == IDLE;
    assign gnt0         = i_req0_valid && (!i_req1_valid || last);
    assign gnt1         = i_req1_valid && (!i_req0_valid || !last);
    assign o_req0_ready = i_rst_n && idle && gnt0;
    assign o_req1_ready = i_rst_n && idle && gnt1;
    assign sel_tgt      = clamp(o_req0_ready ? i_req0_target : i_req1_target, D_MIN, D_MAX);

    // bounded step toward target; the final step is trimmed so it lands exactly on tgt
    assign up     = tgt > o_duty;
    assign diff   = up ? tgt - o_duty : o_duty - tgt;
    assign step   = diff < D_STEP ? diff : D_STEP;
    assign ramp_d = up ? o_duty + step : o_duty - step;

    // next-state logic: accept in IDLE, slew at frame boundaries, settle, then report
    always_comb begin
        state_n = state;
        duty_n  = o_duty;
        tgt_n   = tgt;
        hold_n  = hold_cnt;
        last_n  = last;
        case (state)
            IDLE: if (o_req0_ready || o_req1_ready) begin
                tgt_n   = sel_tgt;
                last_n  = o_req1_ready;
                hold_n  = HOLD_N;
                state_n = sel_tgt != o_duty ? RAMP : HOLD;
            end
            RAMP: if (boundary) begin
                duty_n = ramp_d;
                if (ramp_d == tgt) begin
                    state_n = HOLD;
                    hold_n  = HOLD_N;
                end
            end
            HOLD: if (hold_cnt == '0) state_n = DONE;
                  else if (boundary) hold_n = hold_cnt - 1'b1;
            default: state_n = IDLE;
        endcase
    end

    // state and registered outputs; reset abandons any command in flight
    always_ff @(posedge gen_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            o_duty   <= D_INIT;
            tgt      <= D_INIT;
            hold_cnt <= '0;
            last     <= 1'b1;
            o_done   <= 1'b0;
            o_busy   <= 1'b0;
        end else begin
            state    <= state_n;
            o_duty   <= duty_n;
            tgt      <= tgt_n;
            hold_cnt <= hold_n;
            last     <= last_n;
            o_done   <= state_n == DONE;
            o_busy   <= state_n != IDLE;
        end
    end

endmodule

// File: tb/tb_servo_ramp_ctrl.sv
// tb_servo_ramp_ctrl: scoreboard bench for servo_ramp_ctrl using short frames
module tb_servo_ramp_ctrl;

    logic        gen_clk = 1'b0;
    logic        a_rst_n = 1'b1, b_rst_n = 1'b1;
    logic        a_v0 = 0, a_v1 = 0, b_v0 = 0, b_v1 = 0;
    logic [12:0] a_t0 = 0, a_t1 = 0, b_t0 = 0, b_t1 = 0;
    logic        a_r0, a_r1, b_r0, b_r1;
    logic [12:0] a_duty, b_duty;
    logic        a_fs, b_fs, a_busy, b_busy, a_done, b_done;
    logic [12:0] a_prev = 13'd150, b_prev = 13'd150;
    logic        a_done_q = 0, b_done_q = 0;
    int          errors = 0, checks = 0;
    int          a_dq[$], a_doneq[$], b_dq[$], b_doneq[$];

    always #5 gen_clk = ~gen_clk;

    servo_ramp_ctrl #(.PERIOD(9)) u_a (
        .gen_clk(gen_clk), .i_rst_n(a_rst_n),
        .i_req0_valid(a_v0), .i_req0_target(a_t0), .o_req0_ready(a_r0),
        .i_req1_valid(a_v1), .i_req1_target(a_t1), .o_req1_ready(a_r1),
        .o_duty(a_duty), .o_frame_start(a_fs), .o_busy(a_busy), .o_done(a_done)
    );

    servo_ramp_ctrl #(.PERIOD(9), .STEP(7)) u_b (
        .gen_clk(gen_clk), .i_rst_n(b_rst_n),
        .i_req0_valid(b_v0), .i_req0_target(b_t0), .o_req0_ready(b_r0),
        .i_req1_valid(b_v1), .i_req1_target(b_t1), .o_req1_ready(b_r1),
        .o_duty(b_duty), .o_frame_start(b_fs), .o_busy(b_busy), .o_done(b_done)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // expected duty sequence for one command, plus the duty seen at its done pulse
    task automatic push_ramp(input bit inst, input int from, input int to, input int stp);
        int d = from;
        while (d != to) begin
            if (to > d) d += (to - d < stp) ? to - d : stp;
            else        d -= (d - to < stp) ? d - to : stp;
            if (inst) b_dq.push_back(d); else a_dq.push_back(d);
        end
        if (inst) b_doneq.push_back(to); else a_doneq.push_back(to);
    endtask

    task automatic req(input bit inst, input bit which, input int tgt);
        int  n;
        logic r;
        if (inst) begin
            if (which) begin b_v1 = 1; b_t1 = 13'(tgt); end else begin b_v0 = 1; b_t0 = 13'(tgt); end
        end else begin
            if (which) begin a_v1 = 1; a_t1 = 13'(tgt); end else begin a_v0 = 1; a_t0 = 13'(tgt); end
        end
        for (n = 0; n < 3000; n++) begin
            #1;
            r = inst ? (which ? b_r1 : b_r0) : (which ? a_r1 : a_r0);
            if (r) break;
            @(negedge gen_clk);
        end
        chk("grant_timeout", int'(n < 3000), 1);
        @(posedge gen_clk);
        #1;
        if (inst) begin b_v0 = 0; b_v1 = 0; end else begin a_v0 = 0; a_v1 = 0; end
        chk("busy_after_transfer", inst ? b_busy : a_busy, 1);
    endtask

    task automatic wait_done(input bit inst);
        int n;
        for (n = 0; n < 3000; n++) begin
            @(negedge gen_clk);
            if (inst ? b_done : a_done) break;
        end
        chk("done_timeout", int'(n < 3000), 1);
        @(negedge gen_clk);
        chk("busy_falls_after_done", inst ? b_busy : a_busy, 0);
    endtask

    // wait for the held req1 to be granted on instance A, noting whether a done came first
    task automatic wait_a_r1(output bit seen_done);
        int n;
        seen_done = 0;
        for (n = 0; n < 3000; n++) begin
            @(negedge gen_clk);
            if (a_done) seen_done = 1;
            if (a_r1) break;
        end
        chk("a_r1_grant_timeout", int'(n < 3000), 1);
    endtask

    // monitor for instance A: every duty change and done pulse is matched against the scoreboard
    always @(negedge gen_clk) begin
        if (a_duty !== a_prev) begin
            if (a_dq.size() == 0) chk("a_duty_unexpected", a_duty, a_prev);
            else chk("a_duty_step", a_duty, a_dq.pop_front());
            chk("a_duty_at_frame_start", a_fs, 1);
            chk("a_duty_range", int'(a_duty >= 50 && a_duty <= 250), 1);
            a_prev = a_duty;
        end
        if (a_done) begin
            if (a_doneq.size() == 0) chk("a_done_unexpected", a_done, 0);
            else chk("a_done_duty", a_duty, a_doneq.pop_front());
            chk("a_done_single_cycle", a_done_q, 0);
        end
        a_done_q = a_done;
    end

    // monitor for instance B (STEP=7)
    always @(negedge gen_clk) begin
        if (b_duty !== b_prev) begin
            if (b_dq.size() == 0) chk("b_duty_unexpected", b_duty, b_prev);
            else chk("b_duty_step", b_duty, b_dq.pop_front());
            chk("b_duty_at_frame_start", b_fs, 1);
            chk("b_duty_range", int'(b_duty >= 50 && b_duty <= 250), 1);
            b_prev = b_duty;
        end
        if (b_done) begin
            if (b_doneq.size() == 0) chk("b_done_unexpected", b_done, 0);
            else chk("b_done_duty", b_duty, b_doneq.pop_front());
            chk("b_done_single_cycle", b_done_q, 0);
        end
        b_done_q = b_done;
    end

    initial begin
        bit seen;
        int n;
        #1 a_rst_n = 0; b_rst_n = 0;
        repeat (3) @(negedge gen_clk);
        a_rst_n = 1; b_rst_n = 1;
        #1;
        chk("rst_duty", a_duty, 150);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_frame_start", a_fs, 1);
        chk("rst_b_duty", b_duty, 150);
        // asynchronous reset in the middle of a frame
        repeat (4) @(negedge gen_clk);
        chk("midframe_fs_low", a_fs, 0);
        #2 a_rst_n = 0;
        #1;
        chk("async_rst_fs", a_fs, 1);
        chk("async_rst_duty", a_duty, 150);
        chk("async_rst_busy", a_busy, 0);
        chk("async_rst_done", a_done, 0);
        @(negedge gen_clk);
        a_rst_n = 1;
        // single ramp 150 -> 200
        push_ramp(0, 150, 200, 5);
        req(0, 0, 200);
        wait_done(0);
        chk("single_final", a_duty, 200);
        // arbitration from reset: req0 first, req1 held until done
        a_dq.push_back(150);
        @(negedge gen_clk);
        #2 a_rst_n = 0;
        @(negedge gen_clk);
        a_rst_n = 1;
        a_v0 = 1; a_t0 = 100; a_v1 = 1; a_t1 = 180;
        #1;
        chk("arb_r0_first", a_r0, 1);
        chk("arb_r1_blocked", a_r1, 0);
        push_ramp(0, 150, 100, 5);
        @(posedge gen_clk);
        #1 a_v0 = 0;
        wait_a_r1(seen);
        chk("arb_r1_after_done", seen, 1);
        push_ramp(0, 100, 180, 5);
        @(posedge gen_clk);
        #1 a_v1 = 0;
        wait_done(0);
        chk("arb_final", a_duty, 180);
        // alternation: req0 wins again; its target equals duty (no-op)
        a_v0 = 1; a_t0 = 180; a_v1 = 1; a_t1 = 150;
        #1;
        chk("alt_r0", a_r0, 1);
        chk("alt_r1", a_r1, 0);
        a_doneq.push_back(180);
        @(posedge gen_clk);
        #1 a_v0 = 0;
        chk("noop_busy", a_busy, 1);
        wait_a_r1(seen);
        chk("noop_done_before_r1", seen, 1);
        chk("noop_duty_kept", a_duty, 180);
        push_ramp(0, 180, 150, 5);
        @(posedge gen_clk);
        #1 a_v1 = 0;
        wait_done(0);
        // reset mid-ramp with req1 pending
        a_dq.push_back(155); a_dq.push_back(160); a_dq.push_back(165);
        req(0, 0, 250);
        a_v1 = 1; a_t1 = 60;
        for (n = 0; n < 3000; n++) begin
            @(negedge gen_clk);
            if (a_duty == 165) break;
        end
        chk("midramp_reach_165", int'(n < 3000), 1);
        chk("midramp_r1_low", a_r1, 0);
        a_dq.push_back(150);
        #2 a_rst_n = 0;
        #1;
        chk("midramp_rst_duty", a_duty, 150);
        chk("midramp_rst_busy", a_busy, 0);
        chk("midramp_rst_r1", a_r1, 0);
        @(negedge gen_clk);
        chk("midramp_rst_r1_held", a_r1, 0);
        push_ramp(0, 150, 60, 5);
        a_rst_n = 1;
        #1;
        chk("post_rst_r1_grant", a_r1, 1);
        @(posedge gen_clk);
        #1 a_v1 = 0;
        wait_done(0);
        chk("post_rst_final", a_duty, 60);
        // clamp high and partial steps with STEP=7
        push_ramp(1, 150, 250, 7);
        req(1, 1, 4000);
        wait_done(1);
        chk("clamp_high_final", b_duty, 250);
        push_ramp(1, 250, 50, 7);
        req(1, 1, 48);
        wait_done(1);
        chk("clamp_low_final", b_duty, 50);
        repeat (3) @(negedge gen_clk);
        chk("a_dq_empty", a_dq.size(), 0);
        chk("a_doneq_empty", a_doneq.size(), 0);
        chk("b_dq_empty", b_dq.size(), 0);
        chk("b_doneq_empty", b_doneq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
